// File: rtl/ternary_neuron_seq_if.sv
// Vector-in / neuron-result-out handshake bundle for ternary_neuron_seq.
// The master drives vectors and consumes results; the slave is the sequencer.
interface ternary_neuron_seq_if #(
  parameter int NUM_NEURONS = 4
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [23:0]            in_x;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_NEURONS-1:0] out_y;

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_y
  );
endinterface

// File: rtl/ternary_neuron_seq.sv
// Time-shares one external popcount24 across NUM_NEURONS ternary neurons: y[n] = popcnt(x&wpos) - popcnt(x&wneg) >= thr.
// Define TERNARY_SEQ_PC_PIPE_EN to give each popcount phase a DRIVE and a CAPTURE cycle with pc_cnt registered in between.
module ternary_neuron_seq #(
  parameter int NUM_NEURONS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  ternary_neuron_seq_if.slave      io,
  input  logic [24*NUM_NEURONS-1:0] wpos,
  input  logic [24*NUM_NEURONS-1:0] wneg,
  input  logic [6*NUM_NEURONS-1:0]  thr,
  output logic [23:0]              pc_a,
  input  logic [4:0]               pc_cnt,
  output logic                     busy
);
  localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic [1:0] {IDLE, POS, NEG, EMIT} state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [23:0]            x_r;
  logic [4:0]             pos_r;
  logic [NUM_NEURONS-1:0] y_r;
  logic [NUM_NEURONS-1:0] out_y_r;

  logic [4:0]             cnt;
  logic                   step;
  logic [23:0]            wp_sel;
  logic [23:0]            wn_sel;
  logic signed [5:0]      th_sel;
  logic signed [5:0]      diff;
  logic                   last;
  logic [NUM_NEURONS-1:0] y_nxt;

`ifdef TERNARY_SEQ_PC_PIPE_EN
  // ph=0 is DRIVE (pc_cnt captured into pc_q), ph=1 is CAPTURE (phase completes).
  logic       ph;
  logic [4:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ph   <= 1'b0;
      pc_q <= '0;
    end else if (state == POS || state == NEG) begin
      ph <= ~ph;
      if (!ph) pc_q <= pc_cnt;
    end else begin
      ph <= 1'b0;
    end
  end

  assign cnt  = pc_q;
  assign step = ph;
`else
  assign cnt  = pc_cnt;
  assign step = 1'b1;
`endif

  always_comb begin
    wp_sel = '0;
    wn_sel = '0;
    th_sel = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (int'(idx) == n) begin
        wp_sel = wpos[24*n +: 24];
        wn_sel = wneg[24*n +: 24];
        th_sel = thr[6*n +: 6];
      end
    end
  end

  // Both counts are at most 31, so a 6-bit signed difference cannot wrap.
  assign diff = {1'b0, pos_r} - {1'b0, cnt};
  assign last = (int'(idx) == NUM_NEURONS - 1);

  always_comb begin
    y_nxt = y_r;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (int'(idx) == n) y_nxt[n] = (diff >= th_sel);
    end
  end

  always_comb begin
    case (state)
      POS:     pc_a = x_r & wp_sel;
      NEG:     pc_a = x_r & wn_sel;
      default: pc_a = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      x_r     <= '0;
      pos_r   <= '0;
      y_r     <= '0;
      out_y_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            x_r   <= io.in_x;
            idx   <= '0;
            state <= POS;
          end
        end
        POS: begin
          if (step) begin
            pos_r <= cnt;
            state <= NEG;
          end
        end
        NEG: begin
          if (step) begin
            y_r <= y_nxt;
            if (last) begin
              out_y_r <= y_nxt;
              state   <= EMIT;
            end else begin
              idx   <= idx + 1'b1;
              state <= POS;
            end
          end
        end
        EMIT: begin
          if (io.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE) & ~rst;
  assign io.out_valid = (state == EMIT);
  assign io.out_y     = out_y_r;
  assign busy         = (state != IDLE);
endmodule
